// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem request in flight and queues
// returned words in a small FIFO that decode drains with valid/ready.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] inst;
    logic [WIDTH-1:0] pc;
  } entry_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc, req_pc;
  entry_t           fifo [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;
  logic             push, pop;
  logic             unused_lsb;

  // Redirect targets are word aligned; the low bits never reach the PC.
  assign unused_lsb = ^redirect_pc[1:0];

  assign imem_req   = !reset && state == IDLE && count < CW'(DEPTH) && !redirect;
  assign imem_addr  = pc;
  assign inst_valid = count != '0;
  assign inst       = fifo[head].inst;
  assign inst_pc    = fifo[head].pc;
  assign push       = state == WAIT && imem_ack && !redirect;
  assign pop        = inst_valid && inst_ready && !redirect;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (imem_req) state_nxt = WAIT;
      WAIT:    if (imem_ack) state_nxt = IDLE;
               else if (redirect) state_nxt = DROP;
      DROP:    if (imem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      count  <= '0;
      head   <= '0;
      tail   <= '0;
    end else begin
      state <= state_nxt;
      if (redirect) begin
        pc    <= {redirect_pc[WIDTH-1:2], 2'b00};
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (imem_req) begin
          pc     <= pc + WIDTH'(4);
          req_pc <= pc;
        end
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) fifo[tail] <= '{inst: imem_rdata, pc: req_pc};
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory model answers
// requests with addr+0x100; a monitor checks every decode pop against a queue.
module tb_fetch_unit;
  logic        clk, reset;
  logic        imem_req, imem_ack, redirect, inst_valid, inst_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;

  typedef struct packed {logic [31:0] inst; logic [31:0] pc;} exp_t;
  exp_t        sb_q[$];
  exp_t        e;
  int          checks = 0, failures = 0;
  int          mem_lat;
  bit          pend = 0;
  logic [31:0] paddr;
  int          wcnt;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end

  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic mid(); @(negedge clk); endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic chk_req(string nm, logic r, logic [31:0] a);
    chk({nm, "_req"}, imem_req, r);
    if (r) chk({nm, "_addr"}, imem_addr, a);
  endtask

  task automatic exp_push(logic [31:0] i, logic [31:0] p);
    sb_q.push_back('{inst: i, pc: p});
  endtask

  // Memory: ack mem_lat cycles after the request cycle, data = addr + 0x100.
  initial begin
    imem_ack = 0; imem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      imem_ack = 0;
      if (pend) begin
        if (wcnt <= 1) begin
          imem_ack = 1; imem_rdata = paddr + 32'h100; pend = 0;
        end else wcnt--;
      end
      @(negedge clk);
      if (imem_req) begin pend = 1; paddr = imem_addr; wcnt = mem_lat; end
    end
  end

  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready && !redirect) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_unexpected: got inst %h pc %h expected none", inst, inst_pc);
      end else begin
        e = sb_q.pop_front();
        chk("sb_inst", inst, e.inst);
        chk("sb_pc", inst_pc, e.pc);
      end
    end
  end

  initial begin
    reset = 1; redirect = 0; redirect_pc = '0; inst_ready = 0; mem_lat = 1;
    nxt(); mid(); chk("rst_req", imem_req, 0); chk("rst_valid", inst_valid, 0);
    nxt(); mid(); chk("rst_req2", imem_req, 0); chk("rst_valid2", inst_valid, 0);

    // streaming with 1-cycle memory
    nxt(); reset = 0; inst_ready = 1;
    exp_push(32'h100, 32'h0); exp_push(32'h104, 32'h4);
    exp_push(32'h108, 32'h8); exp_push(32'h10c, 32'hc);
    mid(); chk_req("c0", 1, 32'h0); chk("c0_valid", inst_valid, 0);
    nxt(); mid(); chk_req("c1", 0, 0); chk("c1_valid", inst_valid, 0);
    nxt(); mid(); chk_req("c2", 1, 32'h4); chk("c2_valid", inst_valid, 1);
    nxt(); mid(); chk_req("c3", 0, 0);
    nxt(); mid(); chk_req("c4", 1, 32'h8);
    repeat (4) begin nxt(); mid(); end
    nxt(); reset = 1; mid(); chk("t1_drained", sb_q.size(), 0);

    // decode stall with a full FIFO
    nxt(); reset = 0; inst_ready = 0;
    exp_push(32'h100, 32'h0); exp_push(32'h104, 32'h4);
    mid(); chk_req("d0", 1, 32'h0);
    nxt(); mid(); chk_req("d1", 0, 0);
    nxt(); mid(); chk_req("d2", 1, 32'h4);
    for (int i = 3; i <= 6; i++) begin
      nxt(); mid(); chk_req($sformatf("d%0d_stall", i), 0, 0);
    end
    chk("d6_valid", inst_valid, 1);
    nxt(); inst_ready = 1; mid(); chk_req("d7", 0, 0);
    nxt(); mid(); chk_req("d8_resume", 1, 32'h8);
    nxt(); reset = 1; inst_ready = 0; mid(); chk("t2_drained", sb_q.size(), 0);

    // redirect while waiting on a slow response
    nxt(); reset = 0; inst_ready = 1; mem_lat = 3;
    exp_push(32'h140, 32'h40);
    mid(); chk_req("e0", 1, 32'h0);
    nxt(); redirect = 1; redirect_pc = 32'h41; mid(); chk_req("e1", 0, 0);
    nxt(); redirect = 0; mid(); chk_req("e2_drop", 0, 0); chk("e2_valid", inst_valid, 0);
    nxt(); mid(); chk_req("e3_drop_ack", 0, 0); chk("e3_valid", inst_valid, 0);
    nxt(); mem_lat = 1; mid(); chk_req("e4_target", 1, 32'h40); chk("e4_valid", inst_valid, 0);
    nxt(); mid(); chk("e5_valid", inst_valid, 0);
    nxt(); mid(); chk("e6_valid", inst_valid, 1); chk_req("e6", 1, 32'h44);

    // redirect coinciding with ack and inst_ready, one entry queued
    nxt(); inst_ready = 0; mid(); chk_req("e7", 0, 0);
    nxt(); mid(); chk_req("e8", 1, 32'h48); chk("e8_valid", inst_valid, 1);
    nxt(); inst_ready = 1; redirect = 1; redirect_pc = 32'h203; mid();
    nxt(); redirect = 0; exp_push(32'h300, 32'h200);
    mid(); chk("e10_flush_valid", inst_valid, 0); chk_req("e10_target", 1, 32'h200);
    nxt(); mid(); chk("e11_valid", inst_valid, 0);
    nxt(); mid(); chk_req("e12", 1, 32'h204);
    nxt(); reset = 1; mid(); chk("t34_drained", sb_q.size(), 0);

    // reset while a request is outstanding
    nxt(); reset = 0; mem_lat = 1; inst_ready = 1;
    exp_push(32'h100, 32'h0); exp_push(32'h104, 32'h4); exp_push(32'h100, 32'h0);
    mid(); chk_req("f0", 1, 32'h0);
    nxt(); mid();
    nxt(); mid(); chk_req("f2", 1, 32'h4);
    nxt(); mid();
    nxt(); mem_lat = 2; mid(); chk_req("f4", 1, 32'h8);
    nxt(); reset = 1; mid(); chk("f5_rst_req", imem_req, 0); chk("f5_valid", inst_valid, 0);
    nxt(); reset = 0; mid(); chk_req("f6_restart", 1, 32'h0); chk("f6_valid", inst_valid, 0);
    nxt(); mid(); chk("f7_valid", inst_valid, 0); chk_req("f7", 0, 0);
    nxt(); mid(); chk("f8_valid", inst_valid, 0);
    nxt(); mid(); chk("f9_valid", inst_valid, 1); chk_req("f9", 1, 32'h4);
    nxt(); reset = 1; mid(); chk("t5_drained", sb_q.size(), 0);
    nxt(); mid();

    // PC wrap-around from the top word
    nxt(); reset = 0; mem_lat = 1; redirect = 1; redirect_pc = 32'hffff_ffff;
    exp_push(32'h0000_00fc, 32'hffff_fffc); exp_push(32'h100, 32'h0);
    mid(); chk_req("g0_redir", 0, 0);
    nxt(); redirect = 0; mid(); chk_req("g1_top", 1, 32'hffff_fffc);
    nxt(); mid();
    nxt(); mid(); chk_req("g3_wrap", 1, 32'h0);
    nxt(); mid();
    nxt(); mid();
    nxt(); reset = 1; mid(); chk("t6_drained", sb_q.size(), 0);
    nxt(); mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
